// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: machine width, canonical NOP,
// fetch FSM states and the IF/ID payload record.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT,
    FETCH_RUN,
    FETCH_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // PC is kept as a word address, so sequential advance is +1 word.
  function automatic logic [XLEN-3:0] next_word(input logic [XLEN-3:0] word);
    return word + 1'b1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a full payload, or clears to a bubble
// (valid low, NOP instruction) while keeping the last pc/pc4 fields.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: reset is synchronous and all register updates use <= so every
  // flop samples its inputs from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q.valid <= 1'b0;
      q.pc    <= '0;
      q.pc4   <= '0;
      q.instr <= NOP_INSTR;
    end else if (clear) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/WAIT fetch FSM and
// redirect/flush/stall arbitration in front of the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_read,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_ins,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            misalign_err
);

  // Storing only bits [31:2] makes a misaligned PC unrepresentable.
  logic [XLEN-3:0] pc_word, pc_word_d;
  fetch_state_e    state, state_d;
  logic            misalign_d;
  logic            ifid_load, ifid_clear;
  if_id_t          ifid_d, ifid_q;

  assign imem_addr = {pc_word, 2'b00};
  assign imem_read = (state != FETCH_BOOT) && !stall;

  assign ifid_d = '{
    valid: 1'b1,
    pc:    imem_addr,
    pc4:   {next_word(pc_word), 2'b00},
    instr: imem_ins
  };

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pc_word_d  = pc_word;
    state_d    = state;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      pc_word_d  = redirect_pc[XLEN-1:2];
      ifid_clear = 1'b1;
      state_d    = FETCH_RUN;
    end else if (state == FETCH_BOOT) begin
      // One idle cycle out of reset regardless of stall.
      state_d    = FETCH_RUN;
      ifid_clear = flush;
    end else if (stall) begin
      ifid_clear = flush;
    end else if (imem_ready) begin
      pc_word_d  = next_word(pc_word);
      state_d    = FETCH_RUN;
      ifid_load  = !flush;
      ifid_clear = flush;
    end else begin
      state_d    = FETCH_WAIT;
      ifid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_word      <= RESET_PC[XLEN-1:2];
      state        <= FETCH_BOOT;
      misalign_err <= 1'b0;
    end else begin
      pc_word      <= pc_word_d;
      state        <= state_d;
      misalign_err <= misalign_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .clear (ifid_clear),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_valid = ifid_q.valid;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_instr = ifid_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, wait bubbles, stall,
// redirect (aligned, misaligned, wrapping), flush and reset during wait.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        imem_ready;
  logic [31:0] imem_ins;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h0050_0000;
  endfunction

  assign imem_ins = mem_at(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_read      (imem_read),
    .imem_ready     (imem_ready),
    .imem_ins       (imem_ins),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .misalign_err   (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 00000000", if_id_pc4); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", if_id_instr, NOP); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", imem_read); end
    rst_n = 1'b1;
  endtask

  task automatic test_boot_stream();
    // BOOT cycle: no fetch request yet.
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL boot_read got %b exp 0", imem_read); end
    step();
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL run_read got %b exp 1", imem_read); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (if_id_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_id_pc, 32'(i * 4)); end
      checks++; if (if_id_pc4 !== 32'(i * 4 + 4)) begin errors++; $display("FAIL stream_pc4[%0d] got %h exp %h", i, if_id_pc4, 32'(i * 4 + 4)); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, if_id_valid); end
      checks++; if (if_id_instr !== mem_at(32'(i * 4))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, if_id_instr, mem_at(32'(i * 4))); end
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got %b exp 0", i, if_id_valid); end
      checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL wait_instr[%0d] got %h exp %h", i, if_id_instr, NOP); end
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr[%0d] got %h exp 00000010", i, imem_addr); end
      checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL wait_read[%0d] got %b exp 1", i, imem_read); end
    end
    imem_ready = 1'b1;
    step();
    checks++; if (if_id_pc !== 32'h10) begin errors++; $display("FAIL wait_resume_pc got %h exp 00000010", if_id_pc); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL wait_resume_valid got %b exp 1", if_id_valid); end
    checks++; if (if_id_instr !== mem_at(32'h10)) begin errors++; $display("FAIL wait_resume_instr got %h exp %h", if_id_instr, mem_at(32'h10)); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step(); step();
    checks++; if (if_id_pc !== 32'h8) begin errors++; $display("FAIL stall_setup_pc got %h exp 00000008", if_id_pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (if_id_pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 00000008", i, if_id_pc); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, if_id_valid); end
      checks++; if (if_id_instr !== mem_at(32'h8)) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, if_id_instr, mem_at(32'h8)); end
      checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL stall_read[%0d] got %b exp 0", i, imem_read); end
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 0000000c", i, imem_addr); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_id_pc !== 32'hC) begin errors++; $display("FAIL stall_resume_pc got %h exp 0000000c", if_id_pc); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL redir_instr got %h exp %h", if_id_instr, NOP); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 00000100", imem_addr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL redir_misalign got %b exp 0", misalign_err); end
    step();
    checks++; if (if_id_pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp 00000100", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'h104) begin errors++; $display("FAIL redir_pc4 got %h exp 00000104", if_id_pc4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_valid2 got %b exp 1", if_id_valid); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse got %b exp 1", misalign_err); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL misalign_addr got %h exp 00000100", imem_addr); end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b exp 0", misalign_err); end
    checks++; if (if_id_pc !== 32'h100) begin errors++; $display("FAIL misalign_pc got %h exp 00000100", if_id_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (if_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", if_id_pc); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 00000000", if_id_pc4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", if_id_instr, NOP); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL flush_addr got %h exp 00000004", imem_addr); end
    stall = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL flush_stall_addr got %h exp 00000004", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid got %b exp 0", if_id_valid); end
    flush = 1'b0; stall = 1'b0;
    step();
    checks++; if (if_id_pc !== 32'h4) begin errors++; $display("FAIL flush_resume_pc got %h exp 00000004", if_id_pc); end
    checks++; if (if_id_instr !== mem_at(32'h4)) begin errors++; $display("FAIL flush_resume_instr got %h exp %h", if_id_instr, mem_at(32'h4)); end
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 1'b0;
    step();
    rst_n = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rstwait_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rstwait_pc got %h exp 00000000", if_id_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rstwait_addr got %h exp 00000000", imem_addr); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rstwait_read got %b exp 0", imem_read); end
    rst_n = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rstwait_boot_valid got %b exp 0", if_id_valid); end
    step();
    checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rstwait_first got pc %h valid %b exp 00000000/1", if_id_pc, if_id_valid); end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_wait();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_flush();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of first fetch after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction injected on bubble/flush (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port imem_addr, output, 32: byte address to instruction memory, driven combinationally from the PC register.
REQ-006 SHALL have port imem_read, output, 1: fetch request to instruction memory.
REQ-007 SHALL have port imem_ready, input, 1: instruction memory data valid in the same cycle.
REQ-008 SHALL have port imem_ins, input, 32: instruction returned combinationally for imem_addr.
REQ-009 SHALL have port stall, input, 1: hazard unit hold; freezes PC and IF/ID.
REQ-010 SHALL have port flush, input, 1: invalidates IF/ID contents.
REQ-011 SHALL have port redirect_valid, input, 1: branch/jump taken in a later stage.
REQ-012 SHALL have port redirect_pc, input, 32: target byte address.
REQ-013 SHALL have ports if_id_valid (1), if_id_pc (32), if_id_pc4 (32), if_id_instr (32), all outputs: registered IF/ID payload.
REQ-014 SHALL have port misalign_err, output, 1: one-cycle pulse when redirect_pc[1:0] != 0.

Function
REQ-015 FSM states: BOOT, RUN, WAIT. Reset enters BOOT; BOOT -> RUN after exactly one cycle with imem_read=0.
REQ-016 imem_read = 1 in RUN and WAIT when stall=0; 0 in BOOT or when stall=1.
REQ-017 RUN, stall=0, imem_ready=1: IF/ID <= {valid=1, pc, pc+4, imem_ins}; pc <= pc+4; stay RUN.
REQ-018 RUN/WAIT, stall=0, imem_ready=0: IF/ID valid <= 0, instr <= NOP_INSTR; pc holds; next state WAIT.
REQ-019 WAIT, stall=0, imem_ready=1: behaves as REQ-017; next state RUN.
REQ-020 stall=1 (no flush/redirect): PC, FSM state, and all IF/ID outputs hold their values.
REQ-021 redirect_valid=1: pc <= {redirect_pc[31:2], 2'b00}; IF/ID valid <= 0, instr <= NOP_INSTR; next state RUN; overrides stall and imem_ready.
REQ-022 flush=1 without redirect: IF/ID valid <= 0, instr <= NOP_INSTR; pc advances per REQ-017/018 if stall=0, otherwise holds.
REQ-023 Priority, highest first: reset, redirect_valid, flush, stall, normal fetch.
REQ-024 misalign_err SHALL pulse high for the cycle after redirect_valid=1 with redirect_pc[1:0] != 0; otherwise 0.
REQ-025 PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000; if_id_pc4 wraps identically.
REQ-026 pc[1:0] SHALL always be 2'b00.
REQ-027 Latency: instruction at address A appears on if_id_instr one cycle after imem_addr=A with imem_ready=1.

Reset
REQ-028 With rst_n=0 at a clock edge: pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, misalign_err=0.
REQ-029 Reset asserted mid-WAIT or mid-stall SHALL discard all pending state; no instruction captured in the reset cycle.

Structure
REQ-030 Shared package riscv_pkg SHALL hold NOP_INSTR constant, fetch FSM state typedef, and XLEN=32.
REQ-031 IF/ID register SHALL be a sub-module named if_id_reg (payload, load enable, clear); PC and FSM stay in fetch_stage.

Verification
REQ-032 Reset release, imem_ready=1 constant -> imem_read=0 for 1 cycle, then if_id_pc 0x0, 0x4, 0x8 on successive cycles, valid=1.
REQ-033 imem_ready=0 for 3 cycles at pc=0x10 -> 3 bubbles (valid=0, instr=0x00000013), pc held at 0x10, then 0x10 delivered.
REQ-034 stall=1 for 2 cycles at if_id_pc=0x8 -> outputs frozen at 0x8, imem_read=0; fetch resumes at 0xC.
REQ-035 redirect_valid=1, redirect_pc=0x100, with stall=1 -> next cycle valid=0, imem_addr=0x100; following cycle if_id_pc=0x100.
REQ-036 redirect_pc=0x102 -> misalign_err pulse one cycle, imem_addr=0x100.
REQ-037 Redirect to 0xFFFF_FFFC -> if_id_pc4=0x0, next imem_addr=0x0.
